// File: rtl/mem_stage_pkg.sv
//==============================================================================
// mem_stage_pkg: shared pipeline bus widths, load encodings and field layout
// rev 1.0
//==============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int ES2MS_BUS_W = 75;
  localparam int MS2WS_BUS_W = 70;
  localparam int FWD_BUS_W   = 39;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Field order matches the execute-to-memory bus, MSB first.
  typedef struct packed {
    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es2ms_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
//==============================================================================
// mem_stage_if: execute / write-back / data-SRAM / decode-forward signals
// rev 1.0
//==============================================================================
`default_nettype none

interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                   es_to_ms_valid;
  logic                   ms_allowin;
  logic [ES2MS_BUS_W-1:0] es_to_ms_bus;
  logic                   ws_allowin;
  logic                   ms_to_ws_valid;
  logic [MS2WS_BUS_W-1:0] ms_to_ws_bus;
  logic                   data_sram_data_ok;
  logic [31:0]            data_sram_rdata;
  logic [FWD_BUS_W-1:0]   ms_fwd_bus;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
//==============================================================================
// load_align: selects and extends the addressed byte/half/word of load data
// rev 1.0
//==============================================================================
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_ld_type)
      LD_W:    o_data = i_rdata;
      LD_B:    o_data = ext8(w_byte, 1'b1);
      LD_BU:   o_data = ext8(w_byte, 1'b0);
      LD_H:    o_data = ext16(w_half, 1'b1);
      LD_HU:   o_data = ext16(w_half, 1'b0);
      default: o_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
//==============================================================================
// mem_stage: memory-access pipeline stage with response buffering
// rev 1.0
//==============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  ms_if
);

  logic        r_ms_valid;
  es2ms_t      r_bus;
  logic [31:0] r_rdata_buf;
  logic        r_resp_got;

  es2ms_t      w_in_bus;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_accept;
  logic        w_capture;
  logic        w_load_pending;
  logic [31:0] w_mem_data;
  logic [31:0] w_loaded;
  logic [31:0] w_final_result;

  assign w_in_bus   = es2ms_t'(ms_if.es_to_ms_bus);

  // Stores wait for data_ok too, so only non-memory ops skip the response.
  assign w_ready_go = ~r_bus.mem_req | r_resp_got | ms_if.data_sram_data_ok;
  assign w_allowin  = ~r_ms_valid | (w_ready_go & ms_if.ws_allowin);
  assign w_accept   = ms_if.es_to_ms_valid & w_allowin;

  // Buffer only when the instruction stays; a leaving one uses rdata directly.
  assign w_capture  = ms_if.data_sram_data_ok & r_ms_valid & r_bus.mem_req &
                      ~r_resp_got & ~ms_if.ws_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid  <= 1'b0;
      r_bus       <= '0;
      r_rdata_buf <= '0;
      r_resp_got  <= 1'b0;
    end else begin
      if (w_allowin) begin
        r_ms_valid <= ms_if.es_to_ms_valid;
      end
      if (w_accept) begin
        r_bus      <= w_in_bus;
        r_resp_got <= 1'b0;
      end else if (w_capture) begin
        r_resp_got <= 1'b1;
      end
      if (w_capture) begin
        r_rdata_buf <= ms_if.data_sram_rdata;
      end
    end
  end

  assign w_mem_data = r_resp_got ? r_rdata_buf : ms_if.data_sram_rdata;

  load_align u_load_align (
    .i_ld_type (r_bus.ld_type),
    .i_offset  (r_bus.alu_result[1:0]),
    .i_rdata   (w_mem_data),
    .o_data    (w_loaded)
  );

  assign w_final_result = r_bus.res_from_mem ? w_loaded : r_bus.alu_result;
  assign w_load_pending = r_ms_valid & r_bus.res_from_mem & ~w_ready_go;

  assign ms_if.ms_allowin     = w_allowin;
  assign ms_if.ms_to_ws_valid = r_ms_valid & w_ready_go;
  assign ms_if.ms_to_ws_bus   = {r_bus.gr_we, r_bus.dest, w_final_result, r_bus.pc};
  assign ms_if.ms_fwd_bus     = {r_ms_valid & r_bus.gr_we, r_bus.dest,
                                 w_final_result, w_load_pending};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// tb_mem_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the memory stage. rev 1.0
//==============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Held instruction as seen from outside: fields plus whether its response arrived.
  logic        m_valid, m_req, m_ld, m_we, m_got;
  logic [2:0]  m_ldt;
  logic [4:0]  m_dest;
  logic [31:0] m_alu, m_pc, m_data;

  logic [69:0] xfers[$];
  logic [38:0] last_fwd;

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (int'(off) * 8)) & 32'hFF;
    h = (w >> (int'(off[1]) * 16)) & 32'hFFFF;
    case (t)
      3'd0:    return w;
      3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd3:    return b;
      3'd2:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [74:0] mk(input logic req, input logic ld, input logic [2:0] t,
                                     input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {req, ld, t, we, d, alu, pc};
  endfunction

  function automatic logic [74:0] rand_instr();
    logic [4:0]  d;
    logic [31:0] a, p;
    d = 5'($urandom);
    a = $urandom;
    p = $urandom & 32'hFFFF_FFFC;
    case ($urandom_range(0, 2))
      0:       return mk(1'b0, 1'b0, 3'($urandom), 1'($urandom), d, a, p);
      1:       return mk(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1, d, a, p);
      default: return mk(1'b1, 1'b0, 3'($urandom), 1'b0, d, a, p);
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_req = 0; m_ld = 0; m_we = 0; m_got = 0;
    m_ldt = 0; m_dest = 0; m_alu = 0; m_pc = 0; m_data = 0;
  endtask

  // One clock: drive inputs, compare at negedge, advance the model, move past posedge.
  task automatic step(input logic ev, input logic [74:0] eb, input logic wa,
                      input logic dok, input logic [31:0] rd);
    logic        rdy, vld, allow, lp;
    logic [31:0] res;
    ifc.es_to_ms_valid    = ev;
    ifc.es_to_ms_bus      = eb;
    ifc.ws_allowin        = wa;
    ifc.data_sram_data_ok = dok;
    ifc.data_sram_rdata   = rd;
    @(negedge clk);
    rdy   = !m_req || m_got || dok;
    vld   = m_valid && rdy;
    allow = !m_valid || (rdy && wa);
    lp    = m_valid && m_ld && !rdy;
    res   = m_ld ? ref_load(m_ldt, m_alu[1:0], m_got ? m_data : rd) : m_alu;
    chk("allowin", ifc.ms_allowin, allow);
    chk("ws_valid", ifc.ms_to_ws_valid, vld);
    chk("fwd_we", ifc.ms_fwd_bus[38], m_valid && m_we);
    chk("load_pending", ifc.ms_fwd_bus[0], lp);
    if (vld) chk("ws_bus", ifc.ms_to_ws_bus, {m_we, m_dest, res, m_pc});
    if (m_valid) chk("fwd_dest", ifc.ms_fwd_bus[37:33], m_dest);
    if (m_valid && !lp) chk("fwd_result", ifc.ms_fwd_bus[32:1], res);
    last_fwd = ifc.ms_fwd_bus;
    if (ifc.ms_to_ws_valid && wa) xfers.push_back(ifc.ms_to_ws_bus);
    if (m_valid && m_req && !m_got && dok && !wa) begin
      m_got  = 1;
      m_data = rd;
    end
    if (allow) begin
      m_valid = ev;
      if (ev) begin
        {m_req, m_ld, m_ldt, m_we, m_dest, m_alu, m_pc} = eb;
        m_got = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic wa, input logic dok, input logic [31:0] rd);
    step(1'b0, 75'h0, wa, dok, rd);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_allowin"}, ifc.ms_allowin, 1'b1);
    chk({tag, "_valid"}, ifc.ms_to_ws_valid, 1'b0);
    chk({tag, "_ws_bus"}, ifc.ms_to_ws_bus, 70'h0);
    chk({tag, "_fwd_bus"}, ifc.ms_fwd_bus, 39'h0);
  endtask

  initial begin
    resetn = 1'b0;
    ifc.es_to_ms_valid = 0; ifc.es_to_ms_bus = '0; ifc.ws_allowin = 0;
    ifc.data_sram_data_ok = 0; ifc.data_sram_rdata = '0;
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // ALU pass-through
    xfers.delete();
    step(1, mk(0, 0, 3'd0, 1, 5'd5, 32'h1234_5678, 32'h0000_1000), 1, 0, 0);
    idle(1, 0, 0);
    chk("alu_xfer_count", xfers.size(), 1);
    if (xfers.size() == 1) chk("alu_pass", xfers[0], {1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000});

    // ld.b at offset 3, response three cycles after accept
    xfers.delete();
    step(1, mk(1, 1, LD_B, 1, 5'd7, 32'h0000_0103, 32'h0000_1004), 1, 0, 0);
    idle(1, 0, 32'h1111_1111);
    chk("ldb_pending", last_fwd[0], 1'b1);
    idle(1, 0, 32'h2222_2222);
    idle(1, 1, 32'h80FF_0000);
    chk("ldb_xfer_count", xfers.size(), 1);
    if (xfers.size() == 1) chk("ldb_sext", xfers[0][63:32], 32'hFFFF_FF80);

    // ld.hu at offset 2 with write-back stalled around the response
    xfers.delete();
    step(1, mk(1, 1, LD_HU, 1, 5'd9, 32'h0000_2002, 32'h0000_1008), 0, 0, 0);
    idle(0, 1, 32'hBEEF_0000);
    chk("ldhu_no_pend_dok", last_fwd[0], 1'b0);
    idle(0, 0, 32'h1234_5678);
    chk("ldhu_no_pend_hold", last_fwd[0], 1'b0);
    chk("ldhu_fwd_hold", last_fwd[32:1], 32'h0000_BEEF);
    idle(1, 0, 32'hDEAD_DEAD);
    chk("ldhu_xfer_count", xfers.size(), 1);
    if (xfers.size() == 1) chk("ldhu_result", xfers[0][63:32], 32'h0000_BEEF);

    // Load-use interlock, then a store behind it
    xfers.delete();
    step(1, mk(1, 1, LD_W, 1, 5'd4, 32'h0000_3000, 32'h0000_100C), 1, 0, 0);
    idle(1, 0, 32'h5555_5555);
    chk("ldw_pending", last_fwd[0], 1'b1);
    chk("ldw_fwd_we", last_fwd[38], 1'b1);
    step(1, mk(1, 0, 3'd0, 0, 5'd0, 32'h0000_3004, 32'h0000_1010), 1, 1, 32'hCAFE_F00D);
    idle(1, 0, 32'h0);
    chk("store_fwd_we", last_fwd[38], 1'b0);
    chk("store_no_pend", last_fwd[0], 1'b0);
    idle(1, 1, 32'h0);
    chk("ldw_st_count", xfers.size(), 2);
    if (xfers.size() == 2) chk("ldw_data", xfers[0][63:32], 32'hCAFE_F00D);

    // Back-to-back loads with consecutive responses
    xfers.delete();
    step(1, mk(1, 1, LD_W, 1, 5'd10, 32'h0000_4000, 32'h0000_2000), 1, 0, 0);
    step(1, mk(1, 1, LD_W, 1, 5'd11, 32'h0000_4004, 32'h0000_2004), 1, 1, 32'hAAAA_0001);
    idle(1, 1, 32'hBBBB_0002);
    chk("b2b_count", xfers.size(), 2);
    if (xfers.size() == 2) begin
      chk("b2b_first", xfers[0], {1'b1, 5'd10, 32'hAAAA_0001, 32'h0000_2000});
      chk("b2b_second", xfers[1], {1'b1, 5'd11, 32'hBBBB_0002, 32'h0000_2004});
    end

    // Reset while a load waits for its response
    step(1, mk(1, 1, LD_W, 1, 5'd12, 32'h0000_5000, 32'h0000_3000), 1, 0, 0);
    #2 resetn = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1, 1, 32'h7777_7777);
    chk("post_reset_allowin", last_fwd, 39'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic outstanding, dok;
      outstanding = m_valid && m_req && !m_got;
      dok = outstanding ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
      step($urandom_range(0, 99) < 70, rand_instr(), $urandom_range(0, 99) < 70,
           dok, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits between the execute stage and the write-back stage and drives the `ms_to_ws_bus` that write-back consumes. It absorbs the data-SRAM response (`data_ok`/`rdata`) for requests issued in execute, and extracts and extends load data. It holds one instruction and buffers an early response while write-back stalls. It also exports a forwarding/interlock bus to decode.

## Interface
Parameters:
- none; bus widths are fixed package constants.

Ports:
- `clk`  in  1  core clock
- `resetn`  in  1  asynchronous, active-low reset
- `es_to_ms_valid`  in  1  execute holds a valid instruction for this stage
- `ms_allowin`  out  1  this stage accepts a new instruction this cycle
- `es_to_ms_bus`  in  75  fields, MSB first:
  - `mem_req`[74]: a data request was issued and its address accepted
  - `res_from_mem`[73]
  - `ld_type`[72:70]
  - `gr_we`[69]
  - `dest`[68:64]
  - `alu_result`[63:32]
  - `pc`[31:0]
- `ws_allowin`  in  1  write-back accepts
- `ms_to_ws_valid`  out  1  valid instruction offered to write-back
- `ms_to_ws_bus`  out  70  `{gr_we, dest[4:0], final_result[31:0], pc[31:0]}`
- `data_sram_data_ok`  in  1  response for the oldest outstanding request
- `data_sram_rdata`  in  32  response data
- `ms_fwd_bus`  out  39  `{fwd_we, dest[4:0], final_result[31:0], load_pending}` to decode

## Operation
- **Registers**
  - `ms_valid`.
  - `bus_r` (75 b).
  - `rdata_buf` (32 b).
  - `resp_got` (1 b): the response for the held instruction has already been captured.
- **Accept**
  - `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
  - When `ms_allowin` is high: `ms_valid <= es_to_ms_valid`.
  - When `es_to_ms_valid & ms_allowin`: load `bus_r` and clear `resp_got`.
- **Ready**
  - `ms_ready_go = !mem_req | resp_got | data_sram_data_ok`.
  - Stores also wait for `data_ok`.
- **Response capture**
  - Condition: `data_sram_data_ok & ms_valid & mem_req & !resp_got` and the instruction does not leave this cycle (i.e. `!ws_allowin`).
  - Action: `rdata_buf <= data_sram_rdata` and `resp_got <= 1`.
  - If the instruction leaves in the same cycle, `rdata` is used directly and nothing is buffered.
- **Effective data**: `mem_data = resp_got ? rdata_buf : data_sram_rdata`.
- **Load extraction** (offset = `alu_result[1:0]`)
  - ld.w (000): word.
  - ld.b (001) / ld.bu (011): byte[offset], sign- or zero-extended.
  - ld.h (010) / ld.hu (100): half[offset[1]], sign- or zero-extended.
  - Other `ld_type` codes give 0.
- **Result**: `final_result = res_from_mem ? loaded : alu_result`.
- **To write-back**
  - `ms_to_ws_valid = ms_valid & ms_ready_go`.
  - Bus fields come from `bus_r` and `final_result`.
- **Forward bus**
  - `fwd_we = ms_valid & gr_we`.
  - `load_pending = ms_valid & res_from_mem & !ms_ready_go`; decode must stall on a dest match while this is set.
  - `final_result` on this bus is meaningful only when `load_pending` = 0.
- **Ignored input**: `data_ok` with `!ms_valid`, `!mem_req`, or `resp_got` set is ignored. The protocol guarantees at most one outstanding response.

## Timing
- **Reset (`resetn` = 0, asynchronous)**
  - `ms_valid`, `resp_got`, `bus_r` and `rdata_buf` clear immediately.
  - Outputs: `ms_allowin` = 1, `ms_to_ws_valid` = 0, `ms_to_ws_bus` = 0, `ms_fwd_bus` = 0.
  - Reset mid-wait drops the held instruction and its pending response.
- **Latency**
  - Non-memory instruction: presented to write-back the cycle after acceptance (1 cycle).
  - Memory instruction: presented in the first cycle that `data_ok` is high or `resp_got` is set.
- **Handshake**
  - Transfer to write-back occurs on `ms_to_ws_valid & ws_allowin`.
  - While `ms_to_ws_valid` is high and `ws_allowin` is low, `ms_to_ws_bus` is stable.
- **Back-to-back**: the held instruction leaves and a new one is accepted in the same cycle; `resp_got` clears for the new one.
- **data_ok with `ws_allowin` = 0**: buffered and held; the result is stable on later cycles.

## Structure
- **Shared pipeline package**: bus-width constants (`ES2MS_BUS_W`=75, `MS2WS_BUS_W`=70, `FWD_BUS_W`=39) and `ld_type` encodings.
- **Sub-module**: the combinational extractor is split out as `load_align` (inputs `ld_type`, `offset`, `rdata`; output 32 b).

## Test plan
- **ALU pass-through**: non-memory op, `alu_result`=0x1234_5678, `dest`=5, `ws_allowin`=1 -> next cycle `ms_to_ws_valid`=1, bus = `{1,5,0x12345678,pc}`.
- **ld.b sign extension**: `alu_result[1:0]`=3, `rdata`=0x80FF_0000, `data_ok` 3 cycles after accept -> `final_result`=0xFFFF_FF80.
- **Stalled write-back**
  - ld.hu at offset 2 with `ws_allowin`=0.
  - `data_ok` arrives with `rdata`=0xBEEF_0000, then `rdata` changes.
  - `ws_allowin` rises 2 cycles later -> result 0x0000_BEEF.
  - `load_pending` was 0 from the `data_ok` cycle onward.
- **Load-use interlock**: ld.w waiting -> `load_pending`=1 and `fwd_we`=1 until `data_ok`; a store then flows with `fwd_we`=0.
- **Back-to-back loads**: two ld.w with `data_ok` on consecutive cycles -> two write-back transfers on consecutive cycles, no data mixing.
- **Reset mid-wait**: assert `resetn`=0 while waiting on `data_ok` -> all outputs zero in the same cycle, `ms_allowin`=1 after release.
